cu_seq: RTL and testbench
=========================

CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 The block SHALL have parameter REG_SEL_W, default 4, register-select width.
REQ-002 The block SHALL have parameter ALU_OP_W, default 4, ALU opcode width.
REQ-003 The block SHALL have parameter PC_REG, default 15, register index used as program counter.
REQ-004 The block SHALL have parameter MAX_WAIT, default 15, memory-wait cycles tolerated before fault; range 1..255.
REQ-005 The block SHALL have one clock, clk (in, 1), rising-edge.
REQ-006 The block SHALL have reset rst (in, 1), synchronous, active-high.
REQ-007 The block SHALL have these inputs:
- start (1): leave STOP/HALT.
- ir_cond (4): condition code.
- ir_op (4): opcode.
- ir_ra, ir_rb, ir_rc (REG_SEL_W each): register fields.
- ir_alu (ALU_OP_W): ALU operation.
- status (4): {N,Z,C,V}.
- mem_rdy (1): memory access complete this cycle.
REQ-008 The block SHALL have these outputs:
- sel_a, sel_b, sel_in (REG_SEL_W each).
- oe_a, oe_b, ld_reg_file, post_count_b (1 each).
- mem_rd, mem_wr, ld_ir, ld_status, oe_alu (1 each).
- alu_op (ALU_OP_W).
- state (3).
- fault (1).

Function
REQ-009 States and state encodings SHALL be STOP=0, FETCH=1, EXEC=2, MEM=3, HALT=4, FAULT=5; state drives the current encoding.
REQ-010 Control outputs SHALL be combinational from state, IR fields, status and mem_rdy; every unasserted output is 0, with sel_* = 0 and alu_op = 0.
REQ-011 Transitions from STOP SHALL be: start=1 -> FETCH, otherwise remain in STOP.
REQ-012 In FETCH the block SHALL assert sel_b=PC_REG, oe_b=1 and mem_rd=1; ld_ir and post_count_b equal mem_rdy; mem_rdy=1 -> EXEC.
REQ-013 In EXEC the condition SHALL be evaluated as 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V; codes 8-15 are never true.
REQ-014 In EXEC with the condition false or ir_op=0 (NOP), the block SHALL assert no outputs -> FETCH.
REQ-015 In EXEC with ir_op=1 (ALU), the block SHALL assert sel_a=ir_rb, sel_b=ir_rc, oe_a, oe_b, oe_alu, alu_op=ir_alu, sel_in=ir_ra, ld_reg_file, ld_status -> FETCH.
REQ-016 In EXEC, ir_op=2 (LD) or 3 (ST) SHALL go -> MEM, ir_op=4 (HALT) -> HALT, and ir_op 5-15 -> FAULT; all with no outputs asserted.
REQ-017 In MEM for LD, the block SHALL assert sel_b=ir_rb, oe_b, mem_rd, with sel_in=ir_ra and ld_reg_file equal mem_rdy; mem_rdy=1 -> FETCH.
REQ-018 In MEM for ST, the block SHALL assert sel_b=ir_rb, oe_b, sel_a=ir_ra, oe_a, mem_wr; mem_wr is held until mem_rdy=1 -> FETCH.
REQ-019 The block SHALL keep an internal wait counter of width clog2(MAX_WAIT+1); it clears on entry to FETCH or MEM and increments on each FETCH/MEM cycle with mem_rdy=0.
REQ-020 A FETCH/MEM cycle with mem_rdy=0 and wait counter == MAX_WAIT SHALL go -> FAULT, so the (MAX_WAIT+1)th consecutive not-ready cycle faults; mem_rdy=1 in that same cycle completes normally.
REQ-021 In HALT the block SHALL assert no outputs; start=1 -> FETCH.
REQ-022 In FAULT the block SHALL assert fault=1 and no other outputs; start is ignored and only rst exits.
REQ-023 The block SHALL sample IR fields only through ld_ir timing; ir_* must stay stable from EXEC through MEM completion.

Reset
REQ-024 rst=1 at a rising edge SHALL force state=STOP, wait counter=0 and fault=0, with all outputs 0 the following cycle.
REQ-025 rst SHALL have priority over start, mem_rdy and every transition, including mid-MEM: a pending mem_wr drops after the reset edge.

Verification
REQ-026 Reset, start=1, mem_rdy=1: the bench SHALL check state STOP->FETCH, with FETCH outputs sel_b=15, oe_b=1, mem_rd=1, ld_ir=1, post_count_b=1.
REQ-027 ALU fetch (ir_cond=0, ir_op=1, ra=0, rb=1, rc=2, ir_alu=3): the bench SHALL check that EXEC gives sel_a=1, sel_b=2, sel_in=0, alu_op=3, oe_a/oe_b/oe_alu/ld_reg_file/ld_status=1, and the next state is FETCH.
REQ-028 ir_cond=1 with status Z=0: the bench SHALL check that EXEC asserts no outputs and returns to FETCH; with Z=1 the instruction executes.
REQ-029 ST (ra=3, rb=4) with mem_rdy low for 3 cycles: the bench SHALL check that mem_wr=1, sel_a=3, sel_b=4 are held for 4 cycles, then FETCH.
REQ-030 MAX_WAIT=15 with mem_rdy held low in FETCH: the bench SHALL check that FAULT and fault=1 occur after 16 cycles, that start is ignored, and that rst returns the block to STOP.
REQ-031 HALT opcode followed by start=1: the bench SHALL check HALT with no outputs, then FETCH; ir_op=7 -> FAULT.

Source files
------------

// File: rtl/cu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cu_seq
//  Brief    : Control-unit sequencer: fetch/execute/memory FSM with wait timeout.
//  Revision : 1.0
// ============================================================================
module cu_seq #(
   parameter int REG_SEL_W = 4,
   parameter int ALU_OP_W  = 4,
   parameter int PC_REG    = 15,
   parameter int MAX_WAIT  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           ir_cond,
   input  logic [3:0]           ir_op,
   input  logic [REG_SEL_W-1:0] ir_ra,
   input  logic [REG_SEL_W-1:0] ir_rb,
   input  logic [REG_SEL_W-1:0] ir_rc,
   input  logic [ALU_OP_W-1:0]  ir_alu,
   input  logic [3:0]           status,
   input  logic                 mem_rdy,
   output logic [REG_SEL_W-1:0] sel_a,
   output logic [REG_SEL_W-1:0] sel_b,
   output logic [REG_SEL_W-1:0] sel_in,
   output logic                 oe_a,
   output logic                 oe_b,
   output logic                 ld_reg_file,
   output logic                 post_count_b,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic                 ld_ir,
   output logic                 ld_status,
   output logic                 oe_alu,
   output logic [ALU_OP_W-1:0]  alu_op,
   output logic [2:0]           state,
   output logic                 fault
);

   localparam int                   c_WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
   localparam logic [REG_SEL_W-1:0] c_PC_SEL   = REG_SEL_W'(PC_REG);

   localparam logic [3:0] c_OP_NOP  = 4'd0;
   localparam logic [3:0] c_OP_ALU  = 4'd1;
   localparam logic [3:0] c_OP_LD   = 4'd2;
   localparam logic [3:0] c_OP_ST   = 4'd3;
   localparam logic [3:0] c_OP_HALT = 4'd4;

   typedef enum logic [2:0] {
      S_STOP  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_HALT  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [c_WAIT_W-1:0] r_wait;
   logic [c_WAIT_W-1:0] w_wait_next;
   logic                w_cond_true;

   wire w_n = status[3];
   wire w_z = status[2];
   wire w_c = status[1];
   wire w_v = status[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_STOP;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
      end
   end

   // Condition codes 8-15 are reserved and never satisfied.
   always_comb begin
      w_cond_true = 1'b0;
      case (ir_cond)
         4'd0:    w_cond_true = 1'b1;
         4'd1:    w_cond_true = w_z;
         4'd2:    w_cond_true = ~w_z;
         4'd3:    w_cond_true = w_c;
         4'd4:    w_cond_true = ~w_c;
         4'd5:    w_cond_true = w_n;
         4'd6:    w_cond_true = ~w_n;
         4'd7:    w_cond_true = w_v;
         default: w_cond_true = 1'b0;
      endcase
   end

   always_comb begin
      w_next       = r_state;
      w_wait_next  = '0;
      sel_a        = '0;
      sel_b        = '0;
      sel_in       = '0;
      oe_a         = 1'b0;
      oe_b         = 1'b0;
      ld_reg_file  = 1'b0;
      post_count_b = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      ld_ir        = 1'b0;
      ld_status    = 1'b0;
      oe_alu       = 1'b0;
      alu_op       = '0;
      fault        = 1'b0;

      case (r_state)
         S_STOP: begin
            if (start) w_next = S_FETCH;
         end

         S_FETCH: begin
            sel_b        = c_PC_SEL;
            oe_b         = 1'b1;
            mem_rd       = 1'b1;
            ld_ir        = mem_rdy;
            post_count_b = mem_rdy;
            if (mem_rdy)                  w_next = S_EXEC;
            else if (r_wait == c_WAIT_MAX) w_next = S_FAULT;
            else                          w_wait_next = r_wait + 1'b1;
         end

         S_EXEC: begin
            if (!w_cond_true) begin
               w_next = S_FETCH;
            end else begin
               case (ir_op)
                  c_OP_NOP: w_next = S_FETCH;
                  c_OP_ALU: begin
                     sel_a       = ir_rb;
                     sel_b       = ir_rc;
                     oe_a        = 1'b1;
                     oe_b        = 1'b1;
                     oe_alu      = 1'b1;
                     alu_op      = ir_alu;
                     sel_in      = ir_ra;
                     ld_reg_file = 1'b1;
                     ld_status   = 1'b1;
                     w_next      = S_FETCH;
                  end
                  c_OP_LD, c_OP_ST: w_next = S_MEM;
                  c_OP_HALT:        w_next = S_HALT;
                  default:          w_next = S_FAULT;
               endcase
            end
         end

         // ir_op is held stable here, so it still distinguishes LD from ST.
         S_MEM: begin
            sel_b = ir_rb;
            oe_b  = 1'b1;
            if (ir_op == c_OP_LD) begin
               mem_rd      = 1'b1;
               ld_reg_file = mem_rdy;
               sel_in      = mem_rdy ? ir_ra : '0;
            end else begin
               sel_a  = ir_ra;
               oe_a   = 1'b1;
               mem_wr = 1'b1;
            end
            if (mem_rdy)                  w_next = S_FETCH;
            else if (r_wait == c_WAIT_MAX) w_next = S_FAULT;
            else                          w_wait_next = r_wait + 1'b1;
         end

         S_HALT: begin
            if (start) w_next = S_FETCH;
         end

         S_FAULT: begin
            fault = 1'b1;
         end

         default: w_next = S_FAULT;
      endcase
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cu_seq
//  Brief    : Self-checking bench for cu_seq: vector table, corner sequences,
//             and randomized traffic against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_cu_seq;

   localparam int MAX_WAIT = 15;

   localparam logic [2:0] STOP  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] EXEC  = 3'd2;
   localparam logic [2:0] MEM   = 3'd3;
   localparam logic [2:0] HALT  = 3'd4;
   localparam logic [2:0] FAULT = 3'd5;

   typedef struct packed {
      logic [3:0] sel_a;
      logic [3:0] sel_b;
      logic [3:0] sel_in;
      logic       oe_a;
      logic       oe_b;
      logic       ld_reg_file;
      logic       post_count_b;
      logic       mem_rd;
      logic       mem_wr;
      logic       ld_ir;
      logic       ld_status;
      logic       oe_alu;
      logic [3:0] alu_op;
      logic [2:0] state;
      logic       fault;
   } outs_t;

   typedef struct {
      logic       rst;
      logic       start;
      logic       rdy;
      logic [3:0] cond, op, ra, rb, rc, alu, status;
      outs_t      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start, mem_rdy;
   logic [3:0] ir_cond, ir_op, ir_ra, ir_rb, ir_rc, ir_alu, status;
   logic [3:0] sel_a, sel_b, sel_in, alu_op;
   logic oe_a, oe_b, ld_reg_file, post_count_b, mem_rd, mem_wr, ld_ir, ld_status, oe_alu, fault;
   logic [2:0] state;
   outs_t got;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   cu_seq #(.REG_SEL_W(4), .ALU_OP_W(4), .PC_REG(15), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .start(start), .ir_cond(ir_cond), .ir_op(ir_op),
      .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_rc(ir_rc), .ir_alu(ir_alu), .status(status),
      .mem_rdy(mem_rdy), .sel_a(sel_a), .sel_b(sel_b), .sel_in(sel_in), .oe_a(oe_a),
      .oe_b(oe_b), .ld_reg_file(ld_reg_file), .post_count_b(post_count_b),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .ld_ir(ld_ir), .ld_status(ld_status),
      .oe_alu(oe_alu), .alu_op(alu_op), .state(state), .fault(fault)
   );

   assign got = {sel_a, sel_b, sel_in, oe_a, oe_b, ld_reg_file, post_count_b, mem_rd,
                 mem_wr, ld_ir, ld_status, oe_alu, alu_op, state, fault};

   // Expected output bundles, one per kind of cycle.
   function automatic outs_t o_none(input logic [2:0] s);
      outs_t o = '0;
      o.state = s;
      return o;
   endfunction

   function automatic outs_t o_fetch(input logic rdy);
      outs_t o = o_none(FETCH);
      o.sel_b = 4'd15; o.oe_b = 1'b1; o.mem_rd = 1'b1;
      o.ld_ir = rdy; o.post_count_b = rdy;
      return o;
   endfunction

   function automatic outs_t o_alu(input logic [3:0] ra, rb, rc, alu);
      outs_t o = o_none(EXEC);
      o.sel_a = rb; o.sel_b = rc; o.sel_in = ra; o.alu_op = alu;
      o.oe_a = 1'b1; o.oe_b = 1'b1; o.oe_alu = 1'b1;
      o.ld_reg_file = 1'b1; o.ld_status = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_ld(input logic [3:0] ra, rb, input logic rdy);
      outs_t o = o_none(MEM);
      o.sel_b = rb; o.oe_b = 1'b1; o.mem_rd = 1'b1;
      if (rdy) begin
         o.sel_in = ra; o.ld_reg_file = 1'b1;
      end
      return o;
   endfunction

   function automatic outs_t o_st(input logic [3:0] ra, rb);
      outs_t o = o_none(MEM);
      o.sel_b = rb; o.oe_b = 1'b1; o.sel_a = ra; o.oe_a = 1'b1; o.mem_wr = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_fault();
      outs_t o = o_none(FAULT);
      o.fault = 1'b1;
      return o;
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] s);
      // s = {N,Z,C,V}
      case (c)
         4'd0: return 1'b1;
         4'd1: return s[2];
         4'd2: return !s[2];
         4'd3: return s[1];
         4'd4: return !s[1];
         4'd5: return s[3];
         4'd6: return !s[3];
         4'd7: return s[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic vec_t mkv(input logic r, st, rdy, input logic [3:0] c, op, ra, rb,
                                rc, alu, s, input outs_t e);
      vec_t v;
      v.rst = r; v.start = st; v.rdy = rdy; v.cond = c; v.op = op; v.ra = ra;
      v.rb = rb; v.rc = rc; v.alu = alu; v.status = s; v.exp = e;
      return v;
   endfunction

   task automatic check(input string nm, input outs_t exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h required %h (state got %0d required %0d)",
                  nm, got, exp, got.state, exp.state);
      else
         n_pass++;
   endtask

   // Inputs are already applied; compare mid-cycle, then advance one edge.
   task automatic cycle(input string nm, input outs_t exp);
      @(negedge clk);
      check(nm, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [3:0] c, op, ra, rb, rc, alu);
      ir_cond = c; ir_op = op; ir_ra = ra; ir_rb = rb; ir_rc = rc; ir_alu = alu;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; mem_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t tv[25];

   // Behavioural model state
   logic [2:0] m_state;
   int         m_run;

   initial begin
      rst = 1'b1; start = 1'b0; mem_rdy = 1'b0; status = '0;
      set_ir(0, 0, 0, 0, 0, 0);
      do_reset();

      // ---------------- vector table ----------------
      tv[0]  = mkv(0,0,0, 0,1,0,1,2,3, 4'h0, o_none(STOP));
      tv[1]  = mkv(0,1,1, 0,1,0,1,2,3, 4'h0, o_none(STOP));
      tv[2]  = mkv(0,0,1, 0,1,0,1,2,3, 4'h0, o_fetch(1));
      tv[3]  = mkv(0,0,0, 0,1,0,1,2,3, 4'h0, o_alu(0,1,2,3));
      tv[4]  = mkv(0,0,1, 1,1,5,6,7,9, 4'h0, o_fetch(1));
      tv[5]  = mkv(0,0,0, 1,1,5,6,7,9, 4'h0, o_none(EXEC));
      tv[6]  = mkv(0,0,1, 1,1,5,6,7,9, 4'h4, o_fetch(1));
      tv[7]  = mkv(0,0,0, 1,1,5,6,7,9, 4'h4, o_alu(5,6,7,9));
      tv[8]  = mkv(0,0,1, 0,4,0,0,0,0, 4'h0, o_fetch(1));
      tv[9]  = mkv(0,0,0, 0,4,0,0,0,0, 4'h0, o_none(EXEC));
      tv[10] = mkv(0,0,0, 0,4,0,0,0,0, 4'h0, o_none(HALT));
      tv[11] = mkv(0,1,0, 0,4,0,0,0,0, 4'h0, o_none(HALT));
      tv[12] = mkv(0,0,1, 0,2,8,9,0,0, 4'h0, o_fetch(1));
      tv[13] = mkv(0,0,0, 0,2,8,9,0,0, 4'h0, o_none(EXEC));
      tv[14] = mkv(0,0,0, 0,2,8,9,0,0, 4'h0, o_ld(8,9,0));
      tv[15] = mkv(0,0,1, 0,2,8,9,0,0, 4'h0, o_ld(8,9,1));
      tv[16] = mkv(0,0,0, 0,7,0,0,0,0, 4'h0, o_fetch(0));
      tv[17] = mkv(0,0,1, 0,7,0,0,0,0, 4'h0, o_fetch(1));
      tv[18] = mkv(0,0,0, 0,7,0,0,0,0, 4'h0, o_none(EXEC));
      tv[19] = mkv(0,1,1, 0,7,0,0,0,0, 4'h0, o_fault());
      tv[20] = mkv(1,1,1, 0,7,0,0,0,0, 4'h0, o_fault());
      tv[21] = mkv(0,0,0, 0,7,0,0,0,0, 4'h0, o_none(STOP));
      tv[22] = mkv(0,1,0, 8,1,1,2,3,4, 4'hF, o_none(STOP));
      tv[23] = mkv(0,0,1, 8,1,1,2,3,4, 4'hF, o_fetch(1));
      tv[24] = mkv(0,0,0, 8,1,1,2,3,4, 4'hF, o_none(EXEC));

      for (int i = 0; i < 25; i++) begin
         rst = tv[i].rst; start = tv[i].start; mem_rdy = tv[i].rdy; status = tv[i].status;
         set_ir(tv[i].cond, tv[i].op, tv[i].ra, tv[i].rb, tv[i].rc, tv[i].alu);
         cycle($sformatf("vec%0d", i), tv[i].exp);
      end
      rst = 1'b0;

      // ---------------- store with three stall cycles ----------------
      do_reset();
      status = '0;
      start = 1'b1; cycle("st_stop", o_none(STOP));
      start = 1'b0;
      set_ir(0, 3, 3, 4, 0, 0);
      mem_rdy = 1'b1; cycle("st_fetch", o_fetch(1));
      mem_rdy = 1'b0; cycle("st_exec", o_none(EXEC));
      for (int i = 0; i < 3; i++) cycle("st_wait", o_st(3, 4));
      mem_rdy = 1'b1; cycle("st_done", o_st(3, 4));
      mem_rdy = 1'b0; cycle("st_back", o_fetch(0));

      // ---------------- reset while a store is pending ----------------
      do_reset();
      start = 1'b1; cycle("rm_stop", o_none(STOP));
      start = 1'b0;
      mem_rdy = 1'b1; cycle("rm_fetch", o_fetch(1));
      mem_rdy = 1'b0; cycle("rm_exec", o_none(EXEC));
      cycle("rm_mem", o_st(3, 4));
      rst = 1'b1; mem_rdy = 1'b1; start = 1'b1; cycle("rm_rst", o_st(3, 4));
      rst = 1'b0; start = 1'b0; mem_rdy = 1'b0; cycle("rm_after", o_none(STOP));

      // ---------------- ready on the last tolerated cycle ----------------
      do_reset();
      set_ir(0, 0, 0, 0, 0, 0);
      start = 1'b1; cycle("lw_stop", o_none(STOP));
      start = 1'b0;
      for (int i = 0; i < MAX_WAIT; i++) cycle("lw_stall", o_fetch(0));
      mem_rdy = 1'b1; cycle("lw_last", o_fetch(1));
      mem_rdy = 1'b0; cycle("lw_exec", o_none(EXEC));

      // ---------------- fetch timeout ----------------
      do_reset();
      start = 1'b1; cycle("to_stop", o_none(STOP));
      start = 1'b0;
      for (int i = 0; i < MAX_WAIT + 1; i++) cycle("to_stall", o_fetch(0));
      start = 1'b1; mem_rdy = 1'b1;
      for (int i = 0; i < 3; i++) cycle("to_fault", o_fault());
      rst = 1'b1; cycle("to_rst", o_fault());
      rst = 1'b0; start = 1'b0; cycle("to_stop2", o_none(STOP));

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      m_state = STOP;
      m_run   = 0;
      for (int n = 0; n < 3000; n++) begin
         outs_t e;
         logic  ct;
         rst     = ($urandom_range(0, 63) == 0) ||
                   (m_state == FAULT && $urandom_range(0, 3) == 0);
         start   = 1'($urandom_range(0, 1));
         mem_rdy = ($urandom_range(0, 3) != 0);
         status  = 4'($urandom_range(0, 15));
         if (m_state != EXEC && m_state != MEM) begin
            ir_cond = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                  : 4'($urandom_range(0, 7));
            ir_op   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(5, 15))
                                                   : 4'($urandom_range(0, 4));
            ir_ra   = 4'($urandom_range(0, 15));
            ir_rb   = 4'($urandom_range(0, 15));
            ir_rc   = 4'($urandom_range(0, 15));
            ir_alu  = 4'($urandom_range(0, 15));
         end
         ct = cond_ok(ir_cond, status);

         case (m_state)
            FETCH:   e = o_fetch(mem_rdy);
            EXEC:    e = (ct && ir_op == 4'd1) ? o_alu(ir_ra, ir_rb, ir_rc, ir_alu)
                                               : o_none(EXEC);
            MEM:     e = (ir_op == 4'd2) ? o_ld(ir_ra, ir_rb, mem_rdy) : o_st(ir_ra, ir_rb);
            FAULT:   e = o_fault();
            default: e = o_none(m_state);
         endcase
         cycle("rand", e);

         if (rst) begin
            m_state = STOP;
            m_run   = 0;
         end else begin
            case (m_state)
               STOP, HALT: if (start) m_state = FETCH;
               FETCH, MEM: begin
                  if (mem_rdy) begin
                     m_state = (m_state == FETCH) ? EXEC : FETCH;
                     m_run   = 0;
                  end else begin
                     m_run++;
                     if (m_run == MAX_WAIT + 1) begin
                        m_state = FAULT;
                        m_run   = 0;
                     end
                  end
               end
               EXEC: begin
                  if (!ct || ir_op <= 4'd1) m_state = FETCH;
                  else if (ir_op <= 4'd3)   m_state = MEM;
                  else if (ir_op == 4'd4)   m_state = HALT;
                  else                      m_state = FAULT;
               end
               default: m_state = FAULT;
            endcase
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
